// File: rtl/river_crossing_core_if.sv
// Bus between the river-crossing game core and its surroundings: switch and
// request inputs from the debounced front end, and the status outputs for the
// LED/7-seg drivers. The core uses the slave modport. The front end, or a
// testbench, uses the master modport.
interface river_crossing_core_if #(
    parameter int N_PASS      = 3,
    parameter int PASS_STEPS  = 4,
    parameter int CANOE_STEPS = 16
);
    localparam int PW = (PASS_STEPS > 1) ? $clog2(PASS_STEPS) : 1;
    localparam int CW = (CANOE_STEPS > 1) ? $clog2(CANOE_STEPS) : 1;

    logic                   sw_run;
    logic                   sw_cfg;
    logic [1:0]             difficulty;
    logic [N_PASS-1:0]      req_pass;
    logic                   req_canoe;
    logic [N_PASS-1:0]      crossing;
    logic                   canoe_crossing;
    logic [N_PASS-1:0]      side;
    logic                   canoe_side;
    logic [N_PASS*PW-1:0]   pass_pos;
    logic [CW-1:0]          canoe_pos;
    logic [3:0]             ones;
    logic [3:0]             tens;
    logic [1:0]             game_state;

    modport master (
        output sw_run, sw_cfg, difficulty, req_pass, req_canoe,
        input  crossing, canoe_crossing, side, canoe_side, pass_pos, canoe_pos,
               ones, tens, game_state
    );

    modport slave (
        input  sw_run, sw_cfg, difficulty, req_pass, req_canoe,
        output crossing, canoe_crossing, side, canoe_side, pass_pos, canoe_pos,
               ones, tens, game_state
    );
endinterface

// File: rtl/river_crossing_core.sv
// River-crossing game engine for N_PASS passengers and one canoe.
// - Each move is either one passenger crossing with the canoe, or the empty
//   canoe crossing on its own.
// - Predator/prey pairs are given by the CONFLICT matrix.
// - The move count is kept in BCD and is checked against a limit selected by
//   the difficulty input.
// - Optional idle timeout: define RC_TIMEOUT_EN to enable it.
module river_crossing_core #(
    parameter int                       N_PASS         = 3,
    parameter int                       PASS_STEPS     = 4,
    parameter int                       CANOE_STEPS    = 16,
    parameter int                       TICKS_PER_STEP = 4,
    parameter logic [N_PASS*N_PASS-1:0] CONFLICT       = 9'b000_100_010,
    parameter logic [7:0]               LIMIT0         = 8'h15,
    parameter logic [7:0]               LIMIT1         = 8'h13,
    parameter logic [7:0]               LIMIT2         = 8'h09,
    parameter logic [7:0]               LIMIT3         = 8'h07,
    parameter int                       IDLE_TIMEOUT   = 240
) (
    input logic                   clk_4Hz,
    input logic                   btn_0_out,
    river_crossing_core_if.slave  bus
);
    localparam int PW = (PASS_STEPS > 1) ? $clog2(PASS_STEPS) : 1;
    localparam int CW = (CANOE_STEPS > 1) ? $clog2(CANOE_STEPS) : 1;
    localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [PW-1:0] PASS_END  = PW'(PASS_STEPS - 1);
    localparam logic [CW-1:0] CANOE_END = CW'(CANOE_STEPS - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(TICKS_PER_STEP - 1);

    typedef enum logic [2:0] {IDLE, MOVE_P, MOVE_C, CHECK, OVER} state_t;

    state_t               state, next_state;
    logic [N_PASS-1:0]    crossing, side, legal, grant, start_pass;
    logic                 canoe_crossing, canoe_side, start_canoe;
    logic                 arrive, set_won, set_lost;
    logic [PW-1:0]        pos [N_PASS];
    logic [N_PASS*PW-1:0] pos_flat;
    logic [PW-1:0]        cur_pos;
    logic [CW-1:0]        canoe_pos;
    logic [TW-1:0]        tick;
    logic [3:0]           ones, tens;
    logic [1:0]           game_state;
    logic [7:0]           limit;
    logic                 accept_ok, tick_wrap, pass_end, canoe_end, conflict_hit;
    logic                 timeout_hit;

    assign accept_ok = bus.sw_run && !bus.sw_cfg && (game_state == 2'd2);
    assign tick_wrap = (tick == TICK_END);

    // The canoe, and the passenger riding in it, travel away from the canoe's current bank.
    assign pass_end  = canoe_side ? (cur_pos == '0) : (cur_pos == PASS_END);
    assign canoe_end = canoe_side ? (canoe_pos == '0) : (canoe_pos == CANOE_END);

    // Pick the lowest-indexed legal passenger request, and pick up the moving passenger's lane position.
    always_comb begin
        legal   = bus.req_pass & ~(side ^ {N_PASS{canoe_side}});
        grant   = '0;
        cur_pos = '0;
        for (int i = N_PASS - 1; i >= 0; i--) begin
            if (legal[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
            if (crossing[i]) begin
                cur_pos = pos[i];
            end
        end
    end

    // Check for a predator left alone with its prey on the bank the canoe has just left, and select the move limit.
    always_comb begin
        conflict_hit = 1'b0;
        for (int i = 0; i < N_PASS; i++) begin
            for (int j = 0; j < N_PASS; j++) begin
                if (i != j && CONFLICT[i*N_PASS+j] && side[i] == side[j] && canoe_side != side[i]) begin
                    conflict_hit = 1'b1;
                end
            end
        end
        case (bus.difficulty)
            2'd0:    limit = LIMIT0;
            2'd1:    limit = LIMIT1;
            2'd2:    limit = LIMIT2;
            default: limit = LIMIT3;
        endcase
    end

`ifdef RC_TIMEOUT_EN
    logic [15:0] idle_cnt;

    assign timeout_hit = (state == IDLE) && (game_state == 2'd2) && bus.sw_run
                         && (idle_cnt == 16'(IDLE_TIMEOUT - 1));

    // Count idle cycles of a running game. Restart the count whenever a move is accepted.
    always_ff @(posedge clk_4Hz) begin
        if (btn_0_out || (|start_pass) || start_canoe) begin
            idle_cnt <= '0;
        end else if (state == IDLE && game_state == 2'd2 && bus.sw_run) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM state register; the button forces a new game.
    always_ff @(posedge clk_4Hz) begin
        if (btn_0_out) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, plus the strobes that drive the datapath below.
    always_comb begin
        next_state  = state;
        start_pass  = '0;
        start_canoe = 1'b0;
        arrive      = 1'b0;
        set_won     = 1'b0;
        set_lost    = 1'b0;
        case (state)
            IDLE: begin
                if (accept_ok && (|grant)) begin
                    start_pass = grant;
                    next_state = MOVE_P;
                end else if (accept_ok && bus.req_canoe) begin
                    start_canoe = 1'b1;
                    next_state  = MOVE_C;
                end else if (timeout_hit) begin
                    set_lost   = 1'b1;
                    next_state = OVER;
                end
            end
            MOVE_P: begin
                if (tick_wrap && pass_end) begin
                    arrive     = 1'b1;
                    next_state = CHECK;
                end
            end
            MOVE_C: begin
                if (canoe_end) begin
                    arrive     = 1'b1;
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (&side) begin
                    set_won    = 1'b1;
                    next_state = OVER;
                end else if (conflict_hit || ({tens, ones} == limit)) begin
                    set_lost   = 1'b1;
                    next_state = OVER;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = OVER;
        endcase
    end

    // Datapath: lane counters, banks, BCD move count and game result.
    always_ff @(posedge clk_4Hz) begin
        if (btn_0_out) begin
            crossing       <= '0;
            canoe_crossing <= 1'b0;
            side           <= '0;
            canoe_side     <= 1'b0;
            canoe_pos      <= '0;
            tick           <= '0;
            ones           <= '0;
            tens           <= '0;
            game_state     <= 2'd2;
            for (int i = 0; i < N_PASS; i++) begin
                pos[i] <= '0;
            end
        end else begin
            if (|start_pass) begin
                crossing <= start_pass;
                tick     <= '0;
            end
            if (start_canoe) begin
                canoe_crossing <= 1'b1;
            end
            if ((state == MOVE_P || state == MOVE_C) && !canoe_end) begin
                canoe_pos <= canoe_side ? canoe_pos - CW'(1) : canoe_pos + CW'(1);
            end
            if (state == MOVE_P) begin
                tick <= tick_wrap ? '0 : tick + TW'(1);
                for (int i = 0; i < N_PASS; i++) begin
                    if (crossing[i] && tick_wrap && !pass_end) begin
                        pos[i] <= canoe_side ? pos[i] - PW'(1) : pos[i] + PW'(1);
                    end
                end
            end
            if (arrive) begin
                for (int i = 0; i < N_PASS; i++) begin
                    if (crossing[i]) begin
                        side[i] <= ~canoe_side;
                    end
                end
                canoe_side     <= ~canoe_side;
                crossing       <= '0;
                canoe_crossing <= 1'b0;
                if ({tens, ones} != 8'h99) begin
                    if (ones == 4'd9) begin
                        ones <= 4'd0;
                        tens <= tens + 4'd1;
                    end else begin
                        ones <= ones + 4'd1;
                    end
                end
            end
            if (set_won) begin
                game_state <= 2'd1;
            end
            if (set_lost) begin
                game_state <= 2'd0;
            end
        end
    end

    // Flatten the per-passenger lane counters onto the output bus.
    always_comb begin
        pos_flat = '0;
        for (int i = 0; i < N_PASS; i++) begin
            pos_flat[i*PW +: PW] = pos[i];
        end
    end

    assign bus.crossing       = crossing;
    assign bus.canoe_crossing = canoe_crossing;
    assign bus.side           = side;
    assign bus.canoe_side     = canoe_side;
    assign bus.pass_pos       = pos_flat;
    assign bus.canoe_pos      = canoe_pos;
    assign bus.ones           = ones;
    assign bus.tens           = tens;
    assign bus.game_state     = game_state;
endmodule

// File: tb/tb_river_crossing_core.sv
// Testbench for river_crossing_core with the default three-passenger setup.
// - A game-level model tracks banks, the move count and the result, using the
//   game rules: the predator/prey pairs and the move limits per difficulty.
// - Directed games run first, followed by randomized games.
module tb_river_crossing_core;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    river_crossing_core_if #(.N_PASS(3), .PASS_STEPS(4), .CANOE_STEPS(16)) bus_i ();

    river_crossing_core #(.N_PASS(3)) dut (
        .clk_4Hz   (clk),
        .btn_0_out (rst),
        .bus       (bus_i)
    );

    int testCount = 0;
    int failCount = 0;

    // Game model: banks (0 = left), move count and result (0 lost, 1 won, 2 playing).
    logic [2:0] mSide;
    logic       mCanoe;
    int         mMoves;
    int         mGs;
    int         mDiff;
    bit         run;
    bit         cfg;

    // Predator -> prey pairs, and move limits per difficulty, in decimal.
    int predator [2] = '{0, 1};
    int prey     [2] = '{1, 2};
    int limits   [4] = '{15, 13, 9, 7};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [5:0] posVec(input logic [2:0] s);
        logic [5:0] v;
        for (int i = 0; i < 3; i++) begin
            v[i*2 +: 2] = s[i] ? 2'd3 : 2'd0;
        end
        return v;
    endfunction

    function automatic logic [3:0] canoeVec(input logic c);
        return c ? 4'd15 : 4'd0;
    endfunction

    // Move decision: -1 means the request is dropped, 0..2 means that passenger crosses, 3 means the empty canoe crosses.
    function automatic int pick(input logic [2:0] rp, input bit rc);
        if (mGs != 2 || !run || cfg) return -1;
        for (int i = 0; i < 3; i++) begin
            if (rp[i] && mSide[i] == mCanoe) return i;
        end
        if (rc) return 3;
        return -1;
    endfunction

    task automatic checkIdleState(input string tag);
        checkOutput({tag, ":side"}, {29'd0, bus_i.side}, {29'd0, mSide});
        checkOutput({tag, ":canoe_side"}, {31'd0, bus_i.canoe_side}, {31'd0, mCanoe});
        checkOutput({tag, ":pass_pos"}, {26'd0, bus_i.pass_pos}, {26'd0, posVec(mSide)});
        checkOutput({tag, ":canoe_pos"}, {28'd0, bus_i.canoe_pos}, {28'd0, canoeVec(mCanoe)});
        checkOutput({tag, ":bcd"}, {24'd0, bus_i.tens, bus_i.ones}, 32'((mMoves / 10) * 16 + (mMoves % 10)));
        checkOutput({tag, ":crossing"}, {28'd0, bus_i.crossing, bus_i.canoe_crossing}, 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mSide  = '0;
        mCanoe = 1'b0;
        mMoves = 0;
        mGs    = 2;
    endtask

    task automatic applyStimulus(input logic [2:0] rp, input bit rc, input string tag);
        int         who;
        logic [2:0] nSide;
        logic [2:0] expCross;
        bit         conflict;
        who = pick(rp, rc);
        bus_i.sw_run    = run;
        bus_i.sw_cfg    = cfg;
        bus_i.req_pass  = rp;
        bus_i.req_canoe = rc;
        tick();
        bus_i.req_pass  = '0;
        bus_i.req_canoe = 1'b0;
        if (who < 0) begin
            checkOutput({tag, ":dropped"}, {28'd0, bus_i.crossing, bus_i.canoe_crossing}, 32'd0);
            checkOutput({tag, ":gs_hold"}, {30'd0, bus_i.game_state}, 32'(mGs));
            return;
        end
        expCross = (who < 3) ? (3'b001 << who) : 3'b000;
        checkOutput({tag, ":accept"}, {28'd0, bus_i.crossing, bus_i.canoe_crossing},
                    {28'd0, expCross, (who == 3)});
        nSide = mSide;
        if (who < 3) nSide[who] = ~mCanoe;
        repeat (15) tick();
        checkOutput({tag, ":in_transit"}, {28'd0, bus_i.crossing, bus_i.canoe_crossing},
                    {28'd0, expCross, (who == 3)});
        checkOutput({tag, ":canoe_end"}, {28'd0, bus_i.canoe_pos}, {28'd0, canoeVec(~mCanoe)});
        checkOutput({tag, ":pass_end"}, {26'd0, bus_i.pass_pos}, {26'd0, posVec(nSide)});
        tick();
        mSide  = nSide;
        mCanoe = ~mCanoe;
        if (mMoves < 99) mMoves++;
        checkIdleState({tag, ":arrived"});
        tick();
        conflict = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (mSide[predator[k]] == mSide[prey[k]] && mCanoe != mSide[predator[k]]) conflict = 1'b1;
        end
        if (mSide == 3'b111) mGs = 1;
        else if (conflict) mGs = 0;
        else if (mMoves == limits[mDiff]) mGs = 0;
        checkOutput({tag, ":game_state"}, {30'd0, bus_i.game_state}, 32'(mGs));
    endtask

    initial begin
        run = 1'b1;
        cfg = 1'b0;
        mDiff = 0;
        bus_i.sw_run     = 1'b1;
        bus_i.sw_cfg     = 1'b0;
        bus_i.difficulty = 2'd0;
        bus_i.req_pass   = '0;
        bus_i.req_canoe  = 1'b0;
        tick();

        // After reset every output is zero and the game is in play.
        doReset();
        checkIdleState("reset");
        checkOutput("reset:game_state", {30'd0, bus_i.game_state}, 32'd2);

        // Requests are ignored while the game is stopped or in configuration mode.
        run = 1'b0;
        applyStimulus(3'b010, 1'b0, "run_off");
        run = 1'b1;
        cfg = 1'b1;
        applyStimulus(3'b010, 1'b1, "cfg_on");
        cfg = 1'b0;

        // Passenger 0 crosses first. This leaves 1 and 2 alone on the left bank, so the game is lost.
        applyStimulus(3'b001, 1'b0, "single");
        applyStimulus(3'b010, 1'b0, "after_loss");
        applyStimulus(3'b000, 1'b1, "after_loss_canoe");

        // With simultaneous requests, the lowest legal passenger wins over the others and over the canoe.
        doReset();
        applyStimulus(3'b110, 1'b1, "priority");

        // A reset in the middle of a crossing aborts the move, and the move is not counted.
        doReset();
        bus_i.req_pass = 3'b100;
        tick();
        bus_i.req_pass = '0;
        repeat (5) tick();
        doReset();
        checkIdleState("abort");

        // A seven-move solution at the tightest limit is a win, because the win check comes before the limit check.
        mDiff = 3;
        bus_i.difficulty = 2'd3;
        doReset();
        applyStimulus(3'b010, 1'b0, "win1");
        applyStimulus(3'b000, 1'b1, "win2");
        applyStimulus(3'b001, 1'b0, "win3");
        applyStimulus(3'b010, 1'b0, "win4");
        applyStimulus(3'b100, 1'b0, "win5");
        applyStimulus(3'b000, 1'b1, "win6");
        applyStimulus(3'b010, 1'b0, "win7");
        checkOutput("win:final", {30'd0, bus_i.game_state}, 32'd1);

        // Wasteful canoe trips reach the limit of 7 moves, and the game is lost.
        doReset();
        applyStimulus(3'b010, 1'b0, "waste1");
        for (int m = 0; m < 6; m++) applyStimulus(3'b000, 1'b1, "waste");
        checkOutput("waste:final", {30'd0, bus_i.game_state}, 32'd0);

        // Randomized games.
        for (int g = 0; g < 30; g++) begin
            mDiff = int'($urandom_range(0, 3));
            bus_i.difficulty = 2'(mDiff);
            doReset();
            for (int k = 0; k < 14; k++) begin
                run = ($urandom_range(0, 7) != 0);
                cfg = ($urandom_range(0, 7) == 0);
                applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "random");
            end
            run = 1'b1;
            cfg = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
